// File: rtl/sum_controller.sv
// sum_controller: launches on a rising edge of start, accumulates 1+2+...+N
// one term per step_en tick, then converts the final sum to three BCD digits
// with a double-dabble shifter that runs one bit per clock.
module sum_controller #(
    parameter int NW = 5,
    parameter int SW = 9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [NW-1:0] n,
    input  logic          step_en,
    output logic          busy,
    output logic          done,
    output logic [NW-1:0] count,
    output logic [SW-1:0] sum,
    output logic [11:0]   bcd
);

    localparam int BW = 12 + SW;          // BCD digits on top, binary below
    localparam int CW = $clog2(SW + 1);   // shift counter width

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_CONV  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic            start_q, start_d;
    logic [NW-1:0]   n_q, n_d;
    logic [NW-1:0]   count_q, count_d;
    logic [SW-1:0]   sum_q, sum_d;
    logic [BW-1:0]   shift_q, shift_d;
    logic [CW-1:0]   bitcnt_q, bitcnt_d;
    logic [11:0]     bcd_q, bcd_d;

    logic            launch;
    logic [NW-1:0]   count_inc;
    logic [SW-1:0]   sum_step;
    logic [BW-1:0]   adj;
    logic [BW-1:0]   shifted;

    assign launch    = start && !start_q;
    assign count_inc = count_q + NW'(1);
    assign sum_step  = sum_q + SW'(count_inc);

    // Double-dabble correction: any BCD digit of 5 or more gets +3 so the
    // following left shift carries correctly into the next digit.
    assign adj[SW-1:0] = shift_q[SW-1:0];
    for (genvar gi = 0; gi < 3; gi++) begin : g_nibble
        logic [3:0] nib;
        assign nib = shift_q[SW+4*gi +: 4];
        assign adj[SW+4*gi +: 4] = (nib >= 4'd5) ? (nib + 4'd3) : nib;
    end
    assign shifted = {adj[BW-2:0], 1'b0};

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            start_q  <= 1'b0;
            n_q      <= '0;
            count_q  <= '0;
            sum_q    <= '0;
            shift_q  <= '0;
            bitcnt_q <= '0;
            bcd_q    <= '0;
        end else begin
            state_q  <= state_d;
            start_q  <= start_d;
            n_q      <= n_d;
            count_q  <= count_d;
            sum_q    <= sum_d;
            shift_q  <= shift_d;
            bitcnt_q <= bitcnt_d;
            bcd_q    <= bcd_d;
        end
    end

    // Next-state and datapath updates; everything holds unless a state acts.
    always_comb begin
        state_d  = state_q;
        start_d  = start;          // edge register tracks start in every state
        n_d      = n_q;
        count_d  = count_q;
        sum_d    = sum_q;
        shift_d  = shift_q;
        bitcnt_d = bitcnt_q;
        bcd_d    = bcd_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (launch) begin
                    n_d      = n;
                    count_d  = '0;
                    sum_d    = '0;
                    shift_d  = '0;     // n=0 converts a zero sum directly
                    bitcnt_d = '0;
                    state_d  = (n != '0) ? S_ACCUM : S_CONV;
                end
            end
            S_ACCUM: begin
                if (step_en) begin
                    count_d = count_inc;
                    sum_d   = sum_step;
                    if (count_inc == n_q) begin
                        // Load the converter with the final sum on the same edge.
                        shift_d  = {{12{1'b0}}, sum_step};
                        bitcnt_d = '0;
                        state_d  = S_CONV;
                    end
                end
            end
            S_CONV: begin
                shift_d  = shifted;
                bitcnt_d = bitcnt_q + CW'(1);
                if (bitcnt_q == CW'(SW - 1)) begin
                    bcd_d   = shifted[BW-1:SW];
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy  = (state_q == S_ACCUM) || (state_q == S_CONV);
    assign done  = (state_q == S_DONE);
    assign count = count_q;
    assign sum   = sum_q;
    assign bcd   = bcd_q;

endmodule

// File: doc/sum_controller.md
# sum_controller

Sequencing controller for the triangular-sum datapath: on a start edge it captures the bound N, accumulates 1+2+…+N one term per step enable, then converts the result to three BCD digits for the seven-segment display path. Pacing comes from a single-cycle `step_en` tick produced by the clock divider, so the whole block runs on the fast board clock with no derived clocks. Downstream, the display decoders consume `bcd` when `done` is high.

## Interface
- `NW`, 5: width of bound `n`
- `SW`, 9: accumulator width; must hold N_max·(N_max+1)/2 (496 for NW=5)
- `clk` in 1: board clock, all state on rising edge
- `rst` in 1: asynchronous, active-low reset (0 = reset asserted)
- `start` in 1: level input; a run launches on its rising edge (sampled synchronously)
- `n` in NW: upper bound of the sum, sampled only at launch
- `step_en` in 1: one-cycle pacing tick; gates accumulation only
- `busy` out 1: high in ACCUM and CONV
- `done` out 1: high in DONE
- `count` out NW: current term index (progress display)
- `sum` out SW: running accumulator; final sum once in CONV/DONE
- `bcd` out 12: {hundreds, tens, ones} BCD of final sum, valid while `done`=1

## Operation
- Reset (rst=0, async): state IDLE; `busy`=0, `done`=0, `count`=0, `sum`=0, `bcd`=0, start edge register=0.
- Launch: start=1 while registered previous start=0. Accepted only in IDLE or DONE; ignored in ACCUM/CONV (the edge register still updates every cycle).
- On launch: n_reg←n, `count`←0, `sum`←0, `done`←0; next state ACCUM if n≠0, else CONV.
- ACCUM: each cycle with step_en=1: `count`←count+1, `sum`←sum+count+1. When count+1==n_reg that same edge moves to CONV. step_en=0 holds all state.
- CONV (double-dabble, ungated by step_en): on entry shift register loads {12'b0, final sum}, bit counter=0. Each cycle: every BCD nibble ≥5 gets +3, then shift left 1. After SW shifts, `bcd`←upper 12 bits, state DONE.
- DONE: `done`=1; `sum`, `count`, `bcd` held; leaves only on a new launch or reset.
- Changes on `n` after launch have no effect.
- Arithmetic unsigned; no overflow possible with SW per the parameter rule.
- States: IDLE→(launch)→ACCUM|CONV; ACCUM→(last term)→CONV; CONV→(SW shifts)→DONE; DONE→(launch)→ACCUM|CONV; any→(rst=0)→IDLE.

## Timing
- Launch edge k: `busy`=1 after edge k.
- step_en held 1: ACCUM occupies edges k+1..k+n; CONV edges k+n+1..k+n+SW; `done`=1 and `busy`=0 after edge k+n+SW (n=5, SW=9: 14 cycles).
- n=0: CONV entered at edge k; `done` after edge k+SW.
- Sparse step_en: ACCUM length equals the number of cycles up to the n-th step_en tick; CONV length fixed at SW.
- `bcd` updates only on the CONV→DONE edge; stays stable through a new ACCUM until the next conversion completes.
- Relaunch from DONE: `done` drops the edge after launch.
- Reset mid-run: outputs zero immediately (async); first launch after release behaves as from power-up.

## Test plan
- n=5, step_en=1, start pulse -> `sum`=15, `bcd`=0x015, `done` rises 14 cycles after launch edge, `busy` high for exactly those 14 cycles.
- n=31, step_en=1 -> `sum`=496, `bcd`=0x496, `count`=31, `done` after 40 cycles.
- n=0 -> no ACCUM, `sum`=0, `bcd`=0x000, `done` after 9 cycles.
- n=3, step_en every 4th cycle -> `count` steps 1,2,3 only on ticks, `sum` 1,3,6, `bcd`=0x006; `n` changed to 7 mid-run has no effect.
- start held high through run, plus an extra edge during CONV -> exactly one run; then a fresh edge in DONE with n=4 -> `done` drops, new result `bcd`=0x010.
- rst=0 mid-ACCUM (n=10 at count 4) -> all outputs 0 asynchronously, IDLE; after release, launch with n=2 -> `sum`=3, `bcd`=0x003.
